// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register with load-use hazard detection | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
  parameter int DW    = 16,
  parameter int RW    = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_stall,
  input  logic             ex_flush,
  input  logic             id_valid,
  input  logic [3:0]       id_alu_op,
  input  logic             id_alu_b_imm,
  input  logic [DW-1:0]    id_vX,
  input  logic [DW-1:0]    id_vY,
  input  logic [DW-1:0]    id_imm16,
  input  logic [DW-1:0]    id_pc2,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_halt,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_op,
  output logic             ex_alu_b_imm,
  output logic [DW-1:0]    ex_vX,
  output logic [DW-1:0]    ex_vY,
  output logic [DW-1:0]    ex_imm16,
  output logic [DW-1:0]    ex_pc2,
  output logic [RW-1:0]    ex_rs,
  output logic [RW-1:0]    ex_rt,
  output logic [RW-1:0]    ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_halt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic load_use;
  logic bubble;

  assign load_use = ex_valid & ex_mem_read & ex_reg_write & id_valid &
                    ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));
  // A flush kills the dependent ID instruction, so it need not be held.
  assign stall_id = mem_stall | (load_use & ~ex_flush);
  assign bubble   = ~mem_stall & (ex_flush | load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= '0;
      ex_alu_b_imm <= 1'b0;
      ex_vX        <= '0;
      ex_vY        <= '0;
      ex_imm16     <= '0;
      ex_pc2       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_halt      <= 1'b0;
      bubble_cnt   <= '0;
    end else if (!mem_stall) begin
      if (bubble) begin
        ex_valid     <= 1'b0;
        ex_alu_op    <= '0;
        ex_alu_b_imm <= 1'b0;
        ex_vX        <= '0;
        ex_vY        <= '0;
        ex_imm16     <= '0;
        ex_pc2       <= '0;
        ex_rs        <= '0;
        ex_rt        <= '0;
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_halt      <= 1'b0;
        if (bubble_cnt != {CNT_W{1'b1}}) begin
          bubble_cnt <= bubble_cnt + 1'b1;
        end
      end else begin
        ex_valid     <= id_valid;
        ex_alu_op    <= id_alu_op;
        ex_alu_b_imm <= id_alu_b_imm;
        ex_vX        <= id_vX;
        ex_vY        <= id_vY;
        ex_imm16     <= id_imm16;
        ex_pc2       <= id_pc2;
        ex_rs        <= id_rs;
        ex_rt        <= id_rt;
        ex_rd        <= id_rd;
        // Side-effecting controls of an empty slot must never reach EX.
        ex_reg_write <= id_reg_write & id_valid;
        ex_mem_read  <= id_mem_read  & id_valid;
        ex_mem_write <= id_mem_write & id_valid;
        ex_halt      <= id_halt      & id_valid;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage : directed bench for id_ex_stage | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_stall, ex_flush, id_valid;
  logic [3:0]    id_alu_op;
  logic          id_alu_b_imm;
  logic [DW-1:0] id_vX, id_vY, id_imm16, id_pc2;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          id_rs_used, id_rt_used, id_reg_write, id_mem_read, id_mem_write, id_halt;

  logic          stall_id, ex_valid, ex_alu_b_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt;
  logic [3:0]    ex_alu_op;
  logic [DW-1:0] ex_vX, ex_vY, ex_imm16, ex_pc2;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic [15:0]   bubble_cnt;

  logic          s_stall_id, s_ex_valid, s_ex_alu_b_imm, s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_halt;
  logic [3:0]    s_ex_alu_op;
  logic [DW-1:0] s_ex_vX, s_ex_vY, s_ex_imm16, s_ex_pc2;
  logic [RW-1:0] s_ex_rs, s_ex_rt, s_ex_rd;
  logic [1:0]    s_bubble_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .RW(RW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall), .ex_flush(ex_flush),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_alu_b_imm(id_alu_b_imm),
    .id_vX(id_vX), .id_vY(id_vY), .id_imm16(id_imm16), .id_pc2(id_pc2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_halt(id_halt),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_alu_b_imm(ex_alu_b_imm), .ex_vX(ex_vX), .ex_vY(ex_vY), .ex_imm16(ex_imm16),
    .ex_pc2(ex_pc2), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_halt(ex_halt), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter copy sharing all stimulus, used for the saturation check.
  id_ex_stage #(.DW(DW), .RW(RW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall), .ex_flush(ex_flush),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_alu_b_imm(id_alu_b_imm),
    .id_vX(id_vX), .id_vY(id_vY), .id_imm16(id_imm16), .id_pc2(id_pc2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_halt(id_halt),
    .stall_id(s_stall_id), .ex_valid(s_ex_valid), .ex_alu_op(s_ex_alu_op),
    .ex_alu_b_imm(s_ex_alu_b_imm), .ex_vX(s_ex_vX), .ex_vY(s_ex_vY), .ex_imm16(s_ex_imm16),
    .ex_pc2(s_ex_pc2), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
    .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write),
    .ex_halt(s_ex_halt), .bubble_cnt(s_bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_alu_op = 0; id_alu_b_imm = 0;
    id_vX = 0; id_vY = 0; id_imm16 = 0; id_pc2 = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_rs_used = 0; id_rt_used = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_halt = 0;
  endtask

  task automatic set_load(input logic [RW-1:0] rd);
    clear_id();
    id_valid = 1; id_alu_op = 4'h2; id_alu_b_imm = 1; id_vX = 16'h1111;
    id_imm16 = 16'h0004; id_pc2 = 16'h0102; id_rs = 3'd1; id_rs_used = 1;
    id_rd = rd; id_reg_write = 1; id_mem_read = 1;
  endtask

  initial begin
    rst_n = 0; mem_stall = 0; ex_flush = 0;
    clear_id();
    #12;
    check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
    rst_n = 1;

    // EX = load r3
    set_load(3'd3);
    step();
    check("load_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("load_ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
    check("load_ex_rd", {29'd0, ex_rd}, 32'd3);
    check("load_ex_alu_op", {28'd0, ex_alu_op}, 32'h2);
    check("load_ex_imm16", {16'd0, ex_imm16}, 32'h0004);

    // T2: add reading r3 through rs
    clear_id();
    id_valid = 1; id_alu_op = 4'h1; id_rs = 3'd3; id_rs_used = 1; id_rt = 3'd5;
    id_rt_used = 1; id_rd = 3'd4; id_reg_write = 1; id_vX = 16'haaaa; id_vY = 16'hbbbb;
    id_pc2 = 16'h0104;
    #1;
    check("t2_stall_id", {31'd0, stall_id}, 32'd1);
    step();
    check("t2_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("t2_bubble_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("t2_bubble_vX", {16'd0, ex_vX}, 32'd0);
    check("t2_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
    check("t2_stall_released", {31'd0, stall_id}, 32'd0);
    step();
    check("t2_add_valid", {31'd0, ex_valid}, 32'd1);
    check("t2_add_rd", {29'd0, ex_rd}, 32'd4);
    check("t2_add_vX", {16'd0, ex_vX}, 32'haaaa);
    check("t2_add_vY", {16'd0, ex_vY}, 32'hbbbb);
    check("t2_cnt_after", {16'd0, bubble_cnt}, 32'd1);

    // T3: EX = load r3, ID names r3 in rt but does not read it
    set_load(3'd3);
    step();
    clear_id();
    id_valid = 1; id_alu_op = 4'h1; id_rs = 3'd1; id_rs_used = 1; id_rt = 3'd3;
    id_rt_used = 0; id_rd = 3'd3; id_reg_write = 1; id_vX = 16'h0055;
    #1;
    check("t3_no_hazard_unused", {31'd0, stall_id}, 32'd0);
    step();
    check("t3_add_entered", {31'd0, ex_valid}, 32'd1);
    check("t3_add_vX", {16'd0, ex_vX}, 32'h0055);
    // EX = add r3 (not a load): reader of r3 must not stall
    clear_id();
    id_valid = 1; id_rs = 3'd3; id_rs_used = 1; id_rd = 3'd6; id_reg_write = 1;
    #1;
    check("t3_no_hazard_nonload", {31'd0, stall_id}, 32'd0);
    step();
    check("t3_cnt_unchanged", {16'd0, bubble_cnt}, 32'd1);

    // T4: load to r0 still hazards; flush overrides the stall, counts once
    set_load(3'd0);
    step();
    clear_id();
    id_valid = 1; id_rs = 3'd0; id_rs_used = 1; id_rd = 3'd5; id_reg_write = 1;
    #1;
    check("t4_r0_hazard", {31'd0, stall_id}, 32'd1);
    ex_flush = 1;
    #1;
    check("t4_flush_no_stall", {31'd0, stall_id}, 32'd0);
    step();
    ex_flush = 0;
    check("t4_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("t4_cnt_plus_one", {16'd0, bubble_cnt}, 32'd2);

    // T5: EX = load r2, ID = store using r2 as data; memory stall for 3 edges
    set_load(3'd2);
    step();
    clear_id();
    id_valid = 1; id_alu_op = 4'h2; id_rs = 3'd1; id_rs_used = 1; id_rt = 3'd2;
    id_rt_used = 1; id_mem_write = 1; id_vY = 16'h7777;
    mem_stall = 1; ex_flush = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_stall_id", {31'd0, stall_id}, 32'd1);
      step();
      check("t5_hold_valid", {31'd0, ex_valid}, 32'd1);
      check("t5_hold_rd", {29'd0, ex_rd}, 32'd2);
      check("t5_hold_vX", {16'd0, ex_vX}, 32'h1111);
      check("t5_hold_cnt", {16'd0, bubble_cnt}, 32'd2);
    end
    mem_stall = 0; ex_flush = 0;
    #1;
    check("t5_store_hazard", {31'd0, stall_id}, 32'd1);
    step();
    check("t5_bubble_cnt", {16'd0, bubble_cnt}, 32'd3);
    check("sat_cnt_at_3", {30'd0, s_bubble_cnt}, 32'd3);
    step();
    check("t5_store_valid", {31'd0, ex_valid}, 32'd1);
    check("t5_store_mem_write", {31'd0, ex_mem_write}, 32'd1);
    check("t5_store_vY", {16'd0, ex_vY}, 32'h7777);

    // Empty ID slot: data loads, controls forced off, no count
    clear_id();
    id_reg_write = 1; id_mem_read = 1; id_halt = 1; id_vX = 16'h0abc;
    step();
    check("inv_valid", {31'd0, ex_valid}, 32'd0);
    check("inv_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("inv_halt", {31'd0, ex_halt}, 32'd0);
    check("inv_vX_loaded", {16'd0, ex_vX}, 32'h0abc);
    check("inv_cnt", {16'd0, bubble_cnt}, 32'd3);

    // T6: two more flush bubbles, five in total
    clear_id();
    ex_flush = 1;
    step();
    step();
    ex_flush = 0;
    check("t6_wide_cnt", {16'd0, bubble_cnt}, 32'd5);
    check("t6_sat_cnt", {30'd0, s_bubble_cnt}, 32'd3);

    // T1: asynchronous reset mid-stream
    set_load(3'd7);
    step();
    check("t1_pre_valid", {31'd0, ex_valid}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    check("t1_async_valid", {31'd0, ex_valid}, 32'd0);
    check("t1_async_rd", {29'd0, ex_rd}, 32'd0);
    check("t1_async_mem_read", {31'd0, ex_mem_read}, 32'd0);
    check("t1_async_vX", {16'd0, ex_vX}, 32'd0);
    check("t1_async_cnt", {16'd0, bubble_cnt}, 32'd0);
    #1;
    rst_n = 1;
    step();
    check("t1_first_capture", {29'd0, ex_rd}, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
